// File: rtl/cpu_defs.sv
// cpu_defs: shared write-back select and load-type encodings used by decode and WB.
package cpu_defs;
  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;
  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LHU = 3'b010;
  localparam logic [2:0] LD_LB  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;
endpackage

// File: rtl/load_extract.sv
// load_extract: little-endian byte/halfword extraction with sign or zero extension.
//   raw       - aligned memory word
//   off       - byte offset within the word (address bits [1:0])
//   load_type - LD_* code; unknown codes return the full word
//   value     - extended result
module load_extract
  import cpu_defs::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  off,
  input  logic [2:0]  load_type,
  output logic [31:0] value
);
  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;
  assign shifted = raw >> {off, 3'b000};
  assign b = shifted[7:0];
  // off[0] is ignored for halfwords; misalignment is not trapped in this stage
  assign h = off[1] ? raw[31:16] : raw[15:0];
  always_comb
    value = (load_type == LD_LB)  ? {{24{b[7]}}, b} :
            (load_type == LD_LBU) ? {24'h0, b} :
            (load_type == LD_LH)  ? {{16{h[15]}}, h} :
            (load_type == LD_LHU) ? {16'h0, h} :
            raw;
endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register driving the register-file write port.
//   clk, rst (async, active-low), stall_wb / flush_wb pipeline control,
//   mem_* inputs from the MEM stage, registered outputs wb_valid, write_en,
//   wb_addr, wb_data, and retire_count (instructions that entered WB).
module wb_stage
  import cpu_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_wb,
  input  logic              flush_wb,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic [ADDR_W-1:0] mem_wb_addr,
  input  logic [1:0]        mem_wb_sel,
  input  logic [2:0]        mem_load_type,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_load_data,
  input  logic [DATA_W-1:0] mem_pc_plus4,
  output logic              wb_valid,
  output logic              write_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [31:0]       retire_count
);
  logic [DATA_W-1:0] load_value;
  logic [DATA_W-1:0] result;
  load_extract u_load_extract (
    .raw       (mem_load_data),
    .off       (mem_alu_result[1:0]),
    .load_type (mem_load_type),
    .value     (load_value)
  );
  // reserved select code 11 falls back to the ALU result
  always_comb
    result = (mem_wb_sel == WB_SEL_LOAD) ? load_value :
             (mem_wb_sel == WB_SEL_PC4)  ? mem_pc_plus4 :
             mem_alu_result;
  // a stall keeps write_en high, so the register file rewrites identical data
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wb_valid     <= 1'b0;
      write_en     <= 1'b0;
      wb_addr      <= '0;
      wb_data      <= '0;
      retire_count <= '0;
    end else if (flush_wb) begin
      wb_valid <= 1'b0;
      write_en <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else if (!stall_wb) begin
      wb_valid <= mem_valid;
      write_en <= mem_valid & mem_reg_write & (mem_wb_addr != '0);
      wb_addr  <= mem_wb_addr;
      wb_data  <= result;
      if (mem_valid) retire_count <= retire_count + 32'd1;
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage.
module tb_wb_stage;
  logic        clk;
  logic        rst;
  logic        stall_wb;
  logic        flush_wb;
  logic        mem_valid;
  logic        mem_reg_write;
  logic [4:0]  mem_wb_addr;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_load_type;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_load_data;
  logic [31:0] mem_pc_plus4;
  logic        wb_valid;
  logic        write_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] retire_count;
  int n_checks = 0;
  int n_fails = 0;

  wb_stage dut (
    .clk(clk), .rst(rst), .stall_wb(stall_wb), .flush_wb(flush_wb),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_wb_addr(mem_wb_addr),
    .mem_wb_sel(mem_wb_sel), .mem_load_type(mem_load_type), .mem_alu_result(mem_alu_result),
    .mem_load_data(mem_load_data), .mem_pc_plus4(mem_pc_plus4),
    .wb_valid(wb_valid), .write_en(write_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .retire_count(retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_mem(input logic v, input logic rw, input logic [4:0] a, input logic [1:0] sel,
                         input logic [2:0] lt, input logic [31:0] alu, input logic [31:0] ld,
                         input logic [31:0] pc4);
    mem_valid = v; mem_reg_write = rw; mem_wb_addr = a; mem_wb_sel = sel;
    mem_load_type = lt; mem_alu_result = alu; mem_load_data = ld; mem_pc_plus4 = pc4;
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_case(input string tag, input logic [2:0] lt, input logic [1:0] off,
                           input logic [31:0] exp);
    set_mem(1, 1, 5'd7, 2'b01, lt, {30'h100, off}, 32'h8899AABB, 32'h0);
    step();
    chk(tag, wb_data, exp);
  endtask

  initial begin
    rst = 1'b0; stall_wb = 1'b0; flush_wb = 1'b0;
    set_mem(1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom), 3'($urandom),
            $urandom, $urandom, $urandom);
    step();
    set_mem(1, 1, 5'd9, 2'b00, 3'b000, 32'hDEADBEEF, $urandom, $urandom);
    step();
    chk("rst_valid", {31'h0, wb_valid}, 0);
    chk("rst_we", {31'h0, write_en}, 0);
    chk("rst_addr", {27'h0, wb_addr}, 0);
    chk("rst_data", wb_data, 0);
    chk("rst_count", retire_count, 0);
    rst = 1'b1;
    set_mem(1, 1, 5'd3, 2'b00, 3'b000, 32'h12345678, 32'h0, 32'h0);
    step();
    chk("alu_we", {31'h0, write_en}, 1);
    chk("alu_addr", {27'h0, wb_addr}, 3);
    chk("alu_data", wb_data, 32'h12345678);
    chk("alu_count", retire_count, 1);
    load_case("lb_off2", 3'b011, 2'd2, 32'hFFFFFF99);
    load_case("lbu_off0", 3'b100, 2'd0, 32'h000000BB);
    load_case("lh_off3", 3'b001, 2'd3, 32'hFFFF8899);
    load_case("lhu_off1", 3'b010, 2'd1, 32'h0000AABB);
    load_case("lw_off1", 3'b000, 2'd1, 32'h8899AABB);
    load_case("lb_off1", 3'b011, 2'd1, 32'hFFFFFFAA);
    load_case("lbu_off3", 3'b100, 2'd3, 32'h00000088);
    load_case("lt7_as_lw", 3'b111, 2'd2, 32'h8899AABB);
    chk("load_count", retire_count, 9);
    set_mem(1, 1, 5'd0, 2'b00, 3'b000, 32'h55555555, 32'h0, 32'h0);
    step();
    chk("r0_we", {31'h0, write_en}, 0);
    chk("r0_valid", {31'h0, wb_valid}, 1);
    set_mem(1, 1, 5'd31, 2'b10, 3'b000, 32'h77777777, 32'h0, 32'h00400008);
    step();
    chk("link_data", wb_data, 32'h00400008);
    chk("link_addr", {27'h0, wb_addr}, 31);
    chk("link_we", {31'h0, write_en}, 1);
    set_mem(1, 1, 5'd4, 2'b11, 3'b000, 32'h0BADF00D, 32'h1, 32'h2);
    step();
    chk("sel11_alu", wb_data, 32'h0BADF00D);
    set_mem(1, 0, 5'd4, 2'b00, 3'b000, 32'h1, 32'h0, 32'h0);
    step();
    chk("norw_we", {31'h0, write_en}, 0);
    chk("pre_stall_count", retire_count, 13);
    set_mem(1, 1, 5'd5, 2'b00, 3'b000, 32'hCAFEF00D, 32'h0, 32'h0);
    step();
    stall_wb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_mem(1, 1, 5'(6 + i), 2'b00, 3'b000, 32'h11111111 * (i + 1), 32'h0, 32'h0);
      step();
      chk("stall_data", wb_data, 32'hCAFEF00D);
      chk("stall_addr", {27'h0, wb_addr}, 5);
      chk("stall_we", {31'h0, write_en}, 1);
      chk("stall_count", retire_count, 14);
    end
    stall_wb = 1'b0;
    step();
    chk("release_data", wb_data, 32'h33333333);
    chk("release_addr", {27'h0, wb_addr}, 8);
    chk("release_count", retire_count, 15);
    stall_wb = 1'b1; flush_wb = 1'b1;
    step();
    chk("flush_valid", {31'h0, wb_valid}, 0);
    chk("flush_we", {31'h0, write_en}, 0);
    chk("flush_addr", {27'h0, wb_addr}, 0);
    chk("flush_data", wb_data, 0);
    chk("flush_count", retire_count, 15);
    stall_wb = 1'b0; flush_wb = 1'b0;
    set_mem(1, 1, 5'd12, 2'b00, 3'b000, 32'hA5A5A5A5, 32'h0, 32'h0);
    step();
    chk("post_flush_data", wb_data, 32'hA5A5A5A5);
    chk("post_flush_count", retire_count, 16);
    stall_wb = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("async_valid", {31'h0, wb_valid}, 0);
    chk("async_we", {31'h0, write_en}, 0);
    chk("async_data", wb_data, 0);
    chk("async_count", retire_count, 0);
    @(negedge clk);
    rst = 1'b1; stall_wb = 1'b0;
    force dut.retire_count = 32'hFFFFFFFF;
    #1 release dut.retire_count;
    set_mem(1, 1, 5'd2, 2'b00, 3'b000, 32'h1, 32'h0, 32'h0);
    step();
    chk("wrap_count", retire_count, 0);
    set_mem(0, 1, 5'd2, 2'b00, 3'b000, 32'h2, 32'h0, 32'h0);
    step();
    chk("inv_count", retire_count, 0);
    chk("inv_valid", {31'h0, wb_valid}, 0);
    chk("inv_we", {31'h0, write_en}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
